// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts one bit per cycle so a 31-bit shift costs 31 SHIFT cycles.
// busy stalls the pipeline while shifting; done pulses for one cycle when result is valid.
module seq_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] data,
    input  logic [4:0]  sa,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [1:0]  op_q;
    logic [31:0] work;
    logic [31:0] work_shifted;
    logic        accept;

    assign accept = start && !flush && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // flush overrides every other transition, including the final shift edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if ((op == OP_NOP) || (sa == 5'd0)) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (count == 5'd1) begin
                    state_next = DONE;
                end else begin
                    state_next = SHIFT;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_comb begin
        work_shifted = work;
        case (op_q)
            OP_SLL:  work_shifted = {work[30:0], 1'b0};
            OP_SRL:  work_shifted = {1'b0, work[31:1]};
            OP_SRA:  work_shifted = {work[31], work[31:1]};
            default: work_shifted = work;
        endcase
    end

    // count doubles as the captured shift amount; a reserved op loads zero so it never shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 5'd0;
            op_q  <= 2'b00;
            work  <= 32'h0000_0000;
        end else begin
            if (accept) begin
                work  <= data;
                op_q  <= op;
                count <= (op == OP_NOP) ? 5'd0 : sa;
            end else if (state == SHIFT) begin
                work  <= work_shifted;
                count <= flush ? 5'd0 : (count - 5'd1);
            end else if (flush) begin
                count <= 5'd0;
            end
        end
    end

    assign result = work;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: hand-computed vectors checked with immediate assertions.
module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  sa;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    int busy_cycles;
    int done_pulses;

    seq_shifter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .data   (data),
        .sa     (sa),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        op    = o;
        data  = d;
        sa    = s;
        start = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        data  = 32'h0;
        sa    = 5'd0;
        #2;
        check_output("reset_busy", {31'b0, busy}, 32'd0);
        check_output("reset_done", {31'b0, done}, 32'd0);
        check_output("reset_result", result, 32'h0);
        tick();
        rst_n = 1'b1;

        $display("[TB] SLL by 4");
        apply_stimulus(2'b00, 32'h0000_0001, 5'd4);
        tick();
        start = 1'b0;
        op    = 2'b10;
        data  = 32'hFFFF_FFFF;
        sa    = 5'd9;
        busy_cycles = 0;
        if (busy) busy_cycles++;
        check_output("sll_e0_done", {31'b0, done}, 32'd0);
        repeat (3) begin
            tick();
            if (busy) busy_cycles++;
            if (done) busy_cycles += 100;
        end
        check_output("sll_busy_cycles", busy_cycles, 32'd4);
        tick();
        check_output("sll_done", {31'b0, done}, 32'd1);
        check_output("sll_busy_off", {31'b0, busy}, 32'd0);
        check_output("sll_result", result, 32'h0000_0010);
        tick();
        check_output("sll_done_one_cycle", {31'b0, done}, 32'd0);
        check_output("sll_result_held", result, 32'h0000_0010);

        $display("[TB] SRA by 31");
        apply_stimulus(2'b10, 32'h8000_0000, 5'd31);
        tick();
        start = 1'b0;
        busy_cycles = 0;
        if (busy) busy_cycles++;
        repeat (30) begin
            tick();
            if (busy) busy_cycles++;
            if (done) busy_cycles += 100;
        end
        check_output("sra_busy_cycles", busy_cycles, 32'd31);
        tick();
        check_output("sra_done", {31'b0, done}, 32'd1);
        check_output("sra_result", result, 32'hFFFF_FFFF);
        tick();

        $display("[TB] SRL by 31");
        apply_stimulus(2'b01, 32'h8000_0000, 5'd31);
        tick();
        start = 1'b0;
        repeat (30) tick();
        check_output("srl_not_done_early", {31'b0, done}, 32'd0);
        tick();
        check_output("srl_done", {31'b0, done}, 32'd1);
        check_output("srl_result", result, 32'h0000_0001);
        tick();

        $display("[TB] zero shift and back-to-back start");
        apply_stimulus(2'b01, 32'hDEAD_BEEF, 5'd0);
        tick();
        check_output("zero_done", {31'b0, done}, 32'd1);
        check_output("zero_busy", {31'b0, busy}, 32'd0);
        check_output("zero_result", result, 32'hDEAD_BEEF);
        apply_stimulus(2'b00, 32'h0000_0003, 5'd1);
        tick();
        start = 1'b0;
        check_output("b2b_busy", {31'b0, busy}, 32'd1);
        check_output("b2b_done_low", {31'b0, done}, 32'd0);
        check_output("b2b_captured", result, 32'h0000_0003);
        tick();
        check_output("b2b_done", {31'b0, done}, 32'd1);
        check_output("b2b_result", result, 32'h0000_0006);
        tick();

        $display("[TB] reserved op");
        apply_stimulus(2'b11, 32'h1234_5678, 5'd7);
        tick();
        start = 1'b0;
        check_output("nop_done", {31'b0, done}, 32'd1);
        check_output("nop_busy", {31'b0, busy}, 32'd0);
        check_output("nop_result", result, 32'h1234_5678);
        tick();
        check_output("nop_done_low", {31'b0, done}, 32'd0);

        $display("[TB] start while busy");
        apply_stimulus(2'b00, 32'h0000_0001, 5'd3);
        tick();
        apply_stimulus(2'b01, 32'h0000_FFFF, 5'd2);
        done_pulses = 0;
        tick();
        start = 1'b0;
        check_output("busy_start_ignored", {31'b0, busy}, 32'd1);
        tick();
        if (done) done_pulses++;
        tick();
        check_output("busy_start_result", result, 32'h0000_0008);
        repeat (5) begin
            if (done) done_pulses++;
            tick();
        end
        check_output("busy_start_pulses", done_pulses, 32'd1);
        check_output("busy_start_not_queued", {31'b0, busy}, 32'd0);

        $display("[TB] flush mid-shift");
        apply_stimulus(2'b00, 32'h0000_0001, 5'd5);
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush_busy", {31'b0, busy}, 32'd0);
        done_pulses = 0;
        repeat (6) begin
            if (done) done_pulses++;
            tick();
        end
        check_output("flush_no_done", done_pulses, 32'd0);

        $display("[TB] flush with start in idle");
        apply_stimulus(2'b00, 32'h0000_AAAA, 5'd2);
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check_output("flush_start_busy", {31'b0, busy}, 32'd0);
        check_output("flush_start_done", {31'b0, done}, 32'd0);
        tick();
        check_output("flush_start_idle", {31'b0, busy | done}, 32'd0);

        $display("[TB] flush on final shift");
        apply_stimulus(2'b00, 32'h0000_0001, 5'd2);
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("final_flush_done", {31'b0, done}, 32'd0);
        check_output("final_flush_busy", {31'b0, busy}, 32'd0);
        check_output("final_flush_result", result, 32'h0000_0004);
        tick();
        check_output("final_flush_no_late_done", {31'b0, done}, 32'd0);

        $display("[TB] async reset mid-shift");
        apply_stimulus(2'b10, 32'hF000_0000, 5'd10);
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("areset_busy", {31'b0, busy}, 32'd0);
        check_output("areset_done", {31'b0, done}, 32'd0);
        check_output("areset_result", result, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        apply_stimulus(2'b01, 32'h0000_0100, 5'd8);
        tick();
        start = 1'b0;
        check_output("post_reset_busy", {31'b0, busy}, 32'd1);
        repeat (7) tick();
        check_output("post_reset_not_done", {31'b0, done}, 32'd0);
        tick();
        check_output("post_reset_done", {31'b0, done}, 32'd1);
        check_output("post_reset_result", result, 32'h0000_0001);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
